// File: rtl/tl_inyector.sv
// Transmit-side lane injector: routes upstream words to four lane FIFOs with
// hysteresis back-pressure, and runs a counter request FSM. Option: INYECTOR_TIMEOUT_EN.
module tl_inyector #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [2:0]       Umbral_alto,
    input  logic [2:0]       Umbral_bajo,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             push_out0,
    output logic             push_out1,
    output logic             push_out2,
    output logic             push_out3,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    input  logic             pop_in0,
    input  logic             pop_in1,
    input  logic             pop_in2,
    input  logic             pop_in3,
    input  logic             query_start,
    input  logic [1:0]       query_idx,
    output logic             req,
    output logic [1:0]       idx,
    input  logic [4:0]       contador,
    input  logic             valid,
    output logic             query_done,
    output logic [4:0]       query_count,
    output logic             query_err
);

    localparam int unsigned OW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} q_state_t;

    logic [2:0]    alto, bajo;
    logic [OW-1:0] occ     [4];
    logic [OW-1:0] occ_nxt [4];
    logic [3:0]    paused, paused_nxt;
    logic [3:0]    pop_vec, push_vec;
    logic [1:0]    lane;
    logic          xfer;

    assign lane      = src_data[WIDTH-1:WIDTH-2];
    assign pop_vec   = {pop_in3, pop_in2, pop_in1, pop_in0};
    assign src_ready = !paused[lane] && (occ[lane] < OW'(DEPTH));
    assign xfer      = src_valid && src_ready;

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            push_vec[n]   = xfer && (lane == 2'(n));
            occ_nxt[n]    = occ[n];
            paused_nxt[n] = paused[n];
            // A pop on an empty lane is dropped, so push+pop only cancels when occ > 0
            if (push_vec[n] && !(pop_vec[n] && occ[n] != '0))
                occ_nxt[n] = occ[n] + 1'b1;
            else if (!push_vec[n] && pop_vec[n] && occ[n] != '0)
                occ_nxt[n] = occ[n] - 1'b1;
            if (occ_nxt[n] >= OW'(alto))
                paused_nxt[n] = 1'b1;
            else if (occ_nxt[n] <= OW'(bajo))
                paused_nxt[n] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alto   <= 3'd6;
            bajo   <= 3'd2;
            paused <= '0;
            for (int unsigned n = 0; n < 4; n++) occ[n] <= '0;
        end else begin
            if (init) begin
                alto <= Umbral_alto;
                bajo <= Umbral_bajo;
            end
            paused <= paused_nxt;
            for (int unsigned n = 0; n < 4; n++) occ[n] <= occ_nxt[n];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {push_out3, push_out2, push_out1, push_out0} <= '0;
            data_out0 <= '0;
            data_out1 <= '0;
            data_out2 <= '0;
            data_out3 <= '0;
        end else begin
            {push_out3, push_out2, push_out1, push_out0} <= push_vec;
            if (push_vec[0]) data_out0 <= src_data;
            if (push_vec[1]) data_out1 <= src_data;
            if (push_vec[2]) data_out2 <= src_data;
            if (push_vec[3]) data_out3 <= src_data;
        end
    end

    q_state_t state, state_nxt;
    logic     capture;

`ifdef INYECTOR_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       timeout_hit;
    logic       err_q;
`else
    logic [3:0] unused_timeout;
    assign unused_timeout = 4'(TIMEOUT);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
`ifdef INYECTOR_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            S_IDLE: if (query_start) state_nxt = S_WAIT;
            S_WAIT: begin
                if (valid) begin
                    state_nxt = S_DONE;
                    capture   = 1'b1;
                end
`ifdef INYECTOR_TIMEOUT_EN
                else if (wait_cnt == 4'(TIMEOUT - 1)) begin
                    state_nxt   = S_DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req        = (state == S_WAIT);
    assign query_done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            query_count <= '0;
        end else begin
            if (state == S_IDLE && query_start) idx <= query_idx;
            if (capture) query_count <= contador;
        end
    end

`ifdef INYECTOR_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT && state_nxt == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (capture)          err_q <= 1'b0;
            else if (timeout_hit) err_q <= 1'b1;
        end
    end
    assign query_err = err_q;
`else
    assign query_err = 1'b0;
`endif

endmodule

// File: tb/tb_tl_inyector.sv
// Scoreboard bench for tl_inyector: expected pushes queued on each handshake,
// popped when a push strobe appears; lane occupancy/hysteresis modelled for src_ready.
module tb_tl_inyector;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             init;
    logic [2:0]       Umbral_alto, Umbral_bajo;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             src_ready;
    logic             push_out0, push_out1, push_out2, push_out3;
    logic [WIDTH-1:0] data_out0, data_out1, data_out2, data_out3;
    logic [3:0]       pops;
    logic             query_start;
    logic [1:0]       query_idx;
    logic             req;
    logic [1:0]       idx;
    logic [4:0]       contador;
    logic             valid;
    logic             query_done;
    logic [4:0]       query_count;
    logic             query_err;

    tl_inyector #(.WIDTH(WIDTH), .DEPTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .init(init),
        .Umbral_alto(Umbral_alto), .Umbral_bajo(Umbral_bajo),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .push_out0(push_out0), .push_out1(push_out1), .push_out2(push_out2), .push_out3(push_out3),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
        .pop_in0(pops[0]), .pop_in1(pops[1]), .pop_in2(pops[2]), .pop_in3(pops[3]),
        .query_start(query_start), .query_idx(query_idx), .req(req), .idx(idx),
        .contador(contador), .valid(valid), .query_done(query_done),
        .query_count(query_count), .query_err(query_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned lane;
        int unsigned data;
    } push_t;

    push_t       sb[$];
    int unsigned occ_m[4];
    bit          paused_m[4];
    int unsigned last_m[4];
    int unsigned alto_m, bajo_m;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rq_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            occ_m[n] = 0; paused_m[n] = 0; last_m[n] = 0;
        end
        alto_m = 6; bajo_m = 2;
        sb.delete();
    endtask

    // One clock: check src_ready before the edge, advance the model, check strobes after.
    task automatic step();
        int unsigned l, nx;
        bit          rdy, xfer;
        push_t       e;
        logic [3:0]  pv;
        logic [WIDTH-1:0] dv[4];
        #1;
        l   = src_data[9:8];
        rdy = !paused_m[l] && occ_m[l] < 8;
        check("src_ready", src_ready, rdy);
        xfer = src_valid && rdy;
        if (xfer) begin
            e.lane = l; e.data = src_data;
            sb.push_back(e);
        end
        for (int n = 0; n < 4; n++) begin
            nx = occ_m[n];
            if (xfer && l == n) nx++;
            if (pops[n] && occ_m[n] != 0) nx--;
            occ_m[n] = nx;
            if (nx >= alto_m)      paused_m[n] = 1;
            else if (nx <= bajo_m) paused_m[n] = 0;
        end
        if (init) begin
            alto_m = Umbral_alto; bajo_m = Umbral_bajo;
        end
        @(posedge clk);
        #1;
        pv = {push_out3, push_out2, push_out1, push_out0};
        dv[0] = data_out0; dv[1] = data_out1; dv[2] = data_out2; dv[3] = data_out3;
        check("push_count", $countones(pv), sb.size());
        for (int n = 0; n < 4; n++) begin
            if (pv[n] && sb.size() > 0) begin
                e = sb.pop_front();
                check("push_lane", n, e.lane);
                check("push_data", dv[n], e.data);
                last_m[e.lane] = e.data;
            end
        end
        sb.delete();
        for (int n = 0; n < 4; n++) check("data_out_hold", dv[n], last_m[n]);
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        src_valid = 1'b1; src_data = w;
        step();
        src_valid = 1'b0;
    endtask

    task automatic probe(input logic [WIDTH-1:0] w);
        src_valid = 1'b0; src_data = w;
        step();
    endtask

    task automatic check_all_zero();
        check("rst_push", {push_out3, push_out2, push_out1, push_out0}, 0);
        check("rst_data0", data_out0, 0);
        check("rst_data1", data_out1, 0);
        check("rst_data2", data_out2, 0);
        check("rst_data3", data_out3, 0);
        check("rst_req", req, 0);
        check("rst_idx", idx, 0);
        check("rst_done", query_done, 0);
        check("rst_count", query_count, 0);
        check("rst_err", query_err, 0);
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; Umbral_alto = '0; Umbral_bajo = '0;
        src_valid = 1'b0; src_data = '0; pops = '0;
        query_start = 1'b0; query_idx = '0; contador = '0; valid = 1'b0;
        model_reset();
        #2;
        check_all_zero();
        check("rst_src_ready", src_ready, 1);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // Round-robin words, one per cycle
        src_valid = 1'b1;
        src_data = 10'h000; step();
        src_data = 10'h105; step();
        src_data = 10'h20A; step();
        src_data = 10'h30F; step();
        src_valid = 1'b0;
        pops = 4'hF; probe(10'h000);
        pops = 4'h0; probe(10'h000);

        // Hysteresis with alto=4, bajo=1 on lane 2
        init = 1'b1; Umbral_alto = 3'd4; Umbral_bajo = 3'd1;
        probe(10'h000);
        init = 1'b0;
        for (int i = 0; i < 4; i++) send(10'h200 + 10'(i));
        probe(10'h200);
        probe(10'h000);
        pops = 4'b0100; send(10'h011);
        probe(10'h200);
        probe(10'h200);
        pops = 4'b0001; probe(10'h200);
        pops = 4'b0000; probe(10'h000);

        // Push+pop cancel on lane 1, empty-pop on lane 3
        for (int i = 0; i < 3; i++) send(10'h100 + 10'(i));
        pops = 4'b0010; send(10'h103);
        pops = 4'b0000; probe(10'h100);
        send(10'h104);
        probe(10'h100);
        pops = 4'b1000; probe(10'h300);
        pops = 4'b0000;
        for (int i = 0; i < 4; i++) send(10'h300 + 10'(i));
        probe(10'h300);

        // Counter request answered after three WAIT cycles
        rq_cnt = 0;
        query_idx = 2'd2; query_start = 1'b1; probe(10'h000);
        query_start = 1'b0;
        check("q_req_rise", req, 1);
        check("q_idx", idx, 2);
        if (req) rq_cnt++;
        query_idx = 2'd1; query_start = 1'b1; probe(10'h000);
        query_start = 1'b0;
        check("q_idx_ignore", idx, 2);
        if (req) rq_cnt++;
        probe(10'h000);
        if (req) rq_cnt++;
        valid = 1'b1; contador = 5'd17; probe(10'h000);
        valid = 1'b0; contador = 5'd0;
        if (req) rq_cnt++;
        check("q_req_cycles", rq_cnt, 3);
        check("q_done", query_done, 1);
        check("q_count", query_count, 17);
        check("q_err", query_err, 0);
        probe(10'h000);
        check("q_done_pulse", query_done, 0);
        check("q_req_idle", req, 0);

        // Request with no answer
        query_idx = 2'd3; query_start = 1'b1; probe(10'h000);
        query_start = 1'b0;
        check("t_idx", idx, 3);
`ifdef INYECTOR_TIMEOUT_EN
        rq_cnt = req ? 1 : 0;
        for (int i = 0; i < 40 && !query_done; i++) begin
            probe(10'h000);
            if (req) rq_cnt++;
        end
        check("t_done", query_done, 1);
        check("t_err", query_err, 1);
        check("t_wait_cycles", rq_cnt, 15);
        check("t_count_kept", query_count, 17);
        probe(10'h000);
        query_start = 1'b1; probe(10'h000);
        query_start = 1'b0;
`else
        for (int i = 0; i < 30; i++) begin
            probe(10'h000);
            check("t_req_held", req, 1);
            check("t_no_done", query_done, 0);
        end
`endif

        // Asynchronous reset mid-request with lanes 1 and 3 occupied
        check("pre_rst_req", req, 1);
        send(10'h0AB);
        src_data = 10'h3C5;
        #2 reset = 1'b0;
        #1;
        check_all_zero();
        check("rst_lane3_ready", src_ready, 1);
        model_reset();
        #2 reset = 1'b1;
        send(10'h3C5);
        probe(10'h100);
        check("post_rst_req", req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/tl_inyector.md
# tl_inyector

Transmit-side injector that feeds the PCIe transaction layer's four lane FIFOs from one upstream word stream, and interrogates its per-lane packet counter. It routes each 10-bit word to the lane named by bits [9:8] and asserts the matching push/data pair. It tracks each lane's FIFO occupancy from the observed pops and applies Umbral_alto/Umbral_bajo hysteresis back-pressure upstream. A request FSM drives req/idx and captures contador on valid.

## Interface
- WIDTH, 10, word width; bits [WIDTH-1:WIDTH-2] select the lane
- DEPTH, 8, per-lane FIFO depth used for occupancy tracking
- TIMEOUT, 15, wait-state cycle limit for the counter request (used only with the macro)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- init  in  1  load Umbral_alto/Umbral_bajo into internal registers
- Umbral_alto  in  3  pause threshold
- Umbral_bajo  in  3  resume threshold
- src_valid  in  1  upstream word valid
- src_data  in  WIDTH  upstream word
- src_ready  out  1  upstream may transfer
- push_out0..3  out  1 each  push strobe to lane FIFO n
- data_out0..3  out  WIDTH each  word to lane FIFO n
- pop_in0..3  in  1 each  observed pop of lane FIFO n
- query_start  in  1  start counter request
- query_idx  in  2  lane to query
- req  out  1  counter request to transaction layer
- idx  out  2  lane of the request
- contador  in  5  counter value returned
- valid  in  1  contador valid
- query_done  out  1  one-cycle completion pulse
- query_count  out  5  captured contador
- query_err  out  1  request ended by timeout

## Operation
- Threshold registers: at reset, alto=6 and bajo=2. On init=1, load from ports.
- Each lane n has occ[n] (0..DEPTH) and paused[n].
- Lane of the current word: L = src_data[9:8].
- src_ready = !paused[L] && occ[L] < DEPTH. This is combinational and does not depend on src_valid.
- Transfer when src_valid && src_ready. At the next edge: data_outL <= src_data and push_outL <= 1.
- push_outN returns to 0 on every cycle without a transfer to lane N.
- data_outN holds its last value.
- occ next value: +1 on a push to the lane, −1 on pop_inN, unchanged on both.
- A pop with occ=0 is ignored; occ saturates at 0.
- paused[n] is set when the next occ ≥ alto. It is cleared when the next occ ≤ bajo.
- alto=0 pauses the lane permanently. It is not a disallowed value.
- Counter request FSM:
  - IDLE: on query_start, latch query_idx into idx and go to WAIT. query_start is ignored outside IDLE.
  - WAIT: req=1. On valid, capture contador into query_count, clear query_err, and go to DONE.
  - DONE: query_done=1 for one cycle, then go to IDLE.
- Reset (asynchronous assert, any time) sets:
  - all push_out, data_out, occ, paused, req, idx, query_done, query_count and query_err to 0
  - the FSM to IDLE
  - the thresholds to 6 and 2
- An in-flight request is abandoned on reset.

## Timing
- Latency from src handshake to push_outN is 1 cycle.
- Throughput is one word per cycle.
- Lane-status latency:
  - occ and paused update on the same edge as the push they account for.
  - src_ready reflects occupancy in the following cycle.
- A pop is seen in occ one edge after pop_inN.
- A push and a pop on the same lane in the same cycle leave occ unchanged.
- Request timing:
  - req rises on the edge after query_start.
  - req falls on the edge after valid is sampled.
  - query_done is high on the cycle after the capture edge.
- Minimum request duration is 3 cycles (IDLE→WAIT→DONE→IDLE) when valid is present in the first WAIT cycle.

## Configuration
- INYECTOR_TIMEOUT_EN defined:
  - A 4-bit wait counter runs in WAIT.
  - After TIMEOUT cycles without valid, go to DONE with query_err=1 and query_count unchanged.
- Not defined:
  - WAIT lasts until valid; there is no counter.
  - query_err is tied to 0.

## Test plan
- Reset, then send src words 0x000, 0x105, 0x20A, 0x30F on consecutive cycles -> push_out0..3 pulse once in order, one cycle after each word, with data_out equal to the word. src_ready stays 1.
- With alto=4 and bajo=1, send 4 words to lane 2 with no pops -> src_ready=0 for L=2 from the cycle after the 4th push.
  - Pop three times -> paused clears when occ reaches 1.
  - Lane 0 stays ready throughout.
- Push and pop_in1 together with occ[1]=3 -> occ stays 3. Pop lane 3 with occ=0 -> occ stays 0.
- query_start with query_idx=2, and valid with contador=5'd17 three cycles later -> idx=2, req high for 3 cycles, query_count=17, query_done pulses once, query_err=0.
- With the macro, query_start and no valid -> query_done with query_err=1 after 15 WAIT cycles. Without the macro, req stays high indefinitely.
- Assert reset during WAIT with two lanes partially filled -> all outputs become 0 immediately and the FSM is in IDLE. The next push is accepted at occ=0.
